// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the opcode decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC target selection: JALR > JAL > taken branch > sequential, plus a misalignment flag.
module next_pc_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            branch_taken,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum = rs1_data + imm;
        target   = pc + XLEN'(4);
        if (jalr) begin
            target = jalr_sum & ~XLEN'(1);
        end else if (jal || branch_taken) begin
            target = pc + imm;
        end
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word at a time from instruction
// memory and presents the registered instruction to decode until it is retired.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [6:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    input  logic              branch_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_data,
    output logic              fetch_err,
    output fetch_state_t      dbg_state
);

    // Handshakes: imem_req is a one-cycle pulse with a single read outstanding and
    // imem_rvalid is honoured only in WAIT; instr_valid/instr_ready transfer an
    // instruction on the cycle both are high, and outputs stay frozen while valid waits.

    fetch_state_t    state, state_next;
    logic            armed;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            retire;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc          (pc),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .branch_taken(branch_taken),
        .jal         (jal),
        .jalr        (jalr),
        .target      (target),
        .misaligned  (misaligned)
    );

    assign retire = (state == HOLD) && instr_ready;

    always_comb begin
        state_next = state;
        case (state)
            REQ:     if (armed)       state_next = WAIT;
            WAIT:    if (imem_rvalid) state_next = HOLD;
            HOLD:    if (instr_ready) state_next = misaligned ? ERR : REQ;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    // armed keeps the first request out of the reset cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            armed <= 1'b0;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if ((state == WAIT) && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (retire && !misaligned) begin
                pc <= target;
            end
        end
    end

    assign imem_req    = (state == REQ) && armed;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign fetch_err   = (state == ERR);
    assign opcode      = instr[6:0];
    assign pc_plus4    = pc + XLEN'(4);
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level PC model, randomized memory
// latency and redirects, plus directed boundary cases.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr;
    logic [6:0]   opcode;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         branch_taken;
    logic         jal;
    logic         jalr;
    logic [31:0]  imm;
    logic [31:0]  rs1_data;
    logic         fetch_err;
    fetch_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] cur_pc;
    logic [31:0] pend_addr;
    bit          pending   = 0;
    bit          stale_req = 0;
    int          cnt       = 0;
    int          req_cyc   = 0;
    int          last_lat  = 1;
    int          lat_max   = 1;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch_taken(branch_taken),
        .jal         (jal),
        .jalr        (jalr),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .fetch_err   (fetch_err),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model and request scoreboard; acts on the falling edge, before the driver.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst_n) begin
            pending = 0;
        end else begin
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pending     = 0;
                end
            end
            if (stale_req) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            if (imem_req) begin
                check("one_outstanding", 32'(pending), 32'd0);
                if (exp_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                else                   check("imem_addr", imem_addr, exp_q.pop_front());
                pending   = 1;
                pend_addr = imem_addr;
                last_lat  = $urandom_range(1, lat_max);
                cnt       = last_lat;
                req_cyc   = cyc;
            end
        end
    end

    task automatic drive_idle();
        instr_ready  = 1'b0;
        branch_taken = 1'($urandom);
        jal          = 1'($urandom);
        jalr         = 1'($urandom);
        imm          = $urandom;
        rs1_data     = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        exp_q.delete();
        step();
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err",   32'(fetch_err), 32'd0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc",    pc, RESET_PC);
        check("rst_state", 32'(dbg_state), 32'(REQ));
        step();
        rst_n  = 1'b1;
        cur_pc = RESET_PC;
        exp_q.push_back(RESET_PC);
    endtask

    // Fetch one instruction, hold it dly cycles, then retire it with the given redirect.
    task automatic run_instr(input int dly, input bit br, input bit j, input bit jr,
                             input logic [31:0] im, input logic [31:0] rs, output bit err_exp);
        logic [31:0] w;
        logic [31:0] t;
        err_exp = 0;
        step();
        drive_idle();
        check("valid_drop", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 30 && !instr_valid; i++) step();
        if (!instr_valid) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        w = mem_word(cur_pc);
        check("valid_latency", 32'(cyc - req_cyc), 32'(last_lat + 1));
        check("pc",       pc, cur_pc);
        check("instr",    instr, w);
        check("opcode",   32'(opcode), 32'(w[6:0]));
        check("pc_plus4", pc_plus4, cur_pc + 32'd4);
        for (int i = 0; i < dly; i++) begin
            drive_idle();
            step();
            check("hold_pc",    pc, cur_pc);
            check("hold_instr", instr, w);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_noreq", 32'(imem_req), 32'd0);
        end
        instr_ready  = 1'b1;
        branch_taken = br;
        jal          = j;
        jalr         = jr;
        imm          = im;
        rs1_data     = rs;
        if (jr)          t = (rs + im) & 32'hFFFF_FFFE;
        else if (j | br) t = cur_pc + im;
        else             t = cur_pc + 32'd4;
        if (t[1:0] != 2'b00) begin
            err_exp = 1;
        end else begin
            cur_pc = t;
            exp_q.push_back(t);
        end
    endtask

    task automatic err_check();
        for (int i = 0; i < 4; i++) begin
            step();
            drive_idle();
            instr_ready = 1'($urandom);
            check("err_flag",  32'(fetch_err), 32'd1);
            check("err_valid", 32'(instr_valid), 32'd0);
            check("err_noreq", 32'(imem_req), 32'd0);
            check("err_pc",    pc, cur_pc);
        end
    endtask

    initial begin
        bit          e;
        int          ctl;
        logic [31:0] im;
        logic [31:0] rs;
        foreach (mem[i]) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        do_reset();

        run_instr(0, 0, 0, 0, 32'd0, 32'd0, e);
        check("first_opcode", 32'(opcode), 32'h13);
        run_instr(5, 0, 0, 1, 32'd0, 32'h100, e);
        run_instr(0, 1, 0, 0, 32'hFFFF_FFF8, 32'd0, e);
        run_instr(0, 0, 1, 1, 32'd4, 32'h201, e);
        run_instr(0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC, e);
        run_instr(0, 0, 0, 0, 32'd0, 32'd0, e);
        run_instr(0, 0, 0, 0, 32'd0, 32'd0, e);
        check("wrap_pc", cur_pc, 32'd4);

        lat_max = 3;
        for (int n = 0; n < 150; n++) begin
            ctl = $urandom_range(0, 4);
            im  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 31) == 0) im = im | 32'd2;
            rs  = $urandom & 32'hFFFF_FFFD;
            run_instr($urandom_range(0, 3), ctl == 1, ctl == 2 || ctl == 4, ctl == 3 || ctl == 4,
                      im, rs, e);
            if (e) begin
                err_check();
                do_reset();
            end
        end

        lat_max = 1;
        run_instr(0, 0, 1, 0, 32'd2, 32'd0, e);
        check("err_expected", 32'(e), 32'd1);
        err_check();
        do_reset();
        run_instr(0, 0, 0, 0, 32'd0, 32'd0, e);
        check("restart_pc", cur_pc, RESET_PC + 32'd4);

        do_reset();
        for (int i = 0; i < 10 && !imem_req; i++) step();
        check("wait_req", 32'(imem_req), 32'd1);
        step();
        check("in_wait", 32'(dbg_state), 32'(WAIT));
        do_reset();
        stale_req = 1'b1;
        step();
        stale_req = 1'b0;
        check("stale_in_req", 32'(dbg_state), 32'(REQ));
        run_instr(0, 0, 0, 0, 32'd0, 32'd0, e);
        check("stale_pc", pc, RESET_PC);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
